// File: rtl/game_control.sv
// Keypad movement controller: edge-detects key presses, moves the player on a
// bounded room grid and reports the accepted compass direction as one-hot.
module game_control #(
    parameter int unsigned GRID_MAX = 2,
    parameter int unsigned START_X  = 1,
    parameter int unsigned START_Y  = 1
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_async_ha_i,
    input  logic [3:0] movement,
    output logic [3:0] direction
);

    localparam logic [1:0] GridMax = 2'(GRID_MAX);
    localparam logic [1:0] StartX  = 2'(START_X);
    localparam logic [1:0] StartY  = 2'(START_Y);

    localparam logic [3:0] CodeN = 4'h8;
    localparam logic [3:0] CodeE = 4'h6;
    localparam logic [3:0] CodeS = 4'h2;
    localparam logic [3:0] CodeW = 4'h4;

    localparam logic [3:0] DirNone = 4'b0000;
    localparam logic [3:0] DirN    = 4'b0001;
    localparam logic [3:0] DirE    = 4'b0010;
    localparam logic [3:0] DirS    = 4'b0100;
    localparam logic [3:0] DirW    = 4'b1000;

    logic [3:0] mv_q;
    logic [3:0] mv_prev;
    logic [1:0] x_q, x_d;
    logic [1:0] y_q, y_d;
    logic [3:0] dir_q, dir_d;
    logic       press;

    assign press     = (mv_q != 4'h0) && (mv_q != mv_prev);
    assign direction = dir_q;

    // Bounds are checked on the current position, so the 2-bit counters never wrap.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        if (press) begin
            case (mv_q)
                CodeN: begin
                    if (y_q != 2'd0) begin
                        y_d   = y_q - 2'd1;
                        dir_d = DirN;
                    end else begin
                        dir_d = DirNone;
                    end
                end
                CodeE: begin
                    if (x_q < GridMax) begin
                        x_d   = x_q + 2'd1;
                        dir_d = DirE;
                    end else begin
                        dir_d = DirNone;
                    end
                end
                CodeS: begin
                    if (y_q < GridMax) begin
                        y_d   = y_q + 2'd1;
                        dir_d = DirS;
                    end else begin
                        dir_d = DirNone;
                    end
                end
                CodeW: begin
                    if (x_q != 2'd0) begin
                        x_d   = x_q - 2'd1;
                        dir_d = DirW;
                    end else begin
                        dir_d = DirNone;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_async_ha_i) begin
            mv_q    <= 4'h0;
            mv_prev <= 4'h0;
            x_q     <= StartX;
            y_q     <= StartY;
            dir_q   <= DirNone;
        end else begin
            mv_q    <= movement;
            mv_prev <= mv_q;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: expected directions are queued as each
// key press is driven and compared once the press has had time to take effect.
module tb_game_control;

    logic       clk;
    logic       rst;
    logic [3:0] movement;
    logic [3:0] direction;

    int unsigned vectors;
    int unsigned miscompares;
    logic [3:0]  exp_q[$];

    game_control #(
        .GRID_MAX(2),
        .START_X (1),
        .START_Y (1)
    ) dut (
        .clk_50MHz_i   (clk),
        .rst_async_ha_i(rst),
        .movement      (movement),
        .direction     (direction)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: direction=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Pop the oldest queued expectation and compare it with the live output.
    task automatic pop_check(input string tag);
        logic [3:0] exp;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty, direction=%b expected=none", tag, direction);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, direction, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst      = 1'b1;
        movement = 4'h0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive a code for 'hold' clocks, return to idle, queue the expected result
    // and check it once the two-edge latency has elapsed.
    task automatic press(input string tag, input logic [3:0] code, input int hold,
                         input logic [3:0] exp);
        movement = code;
        exp_q.push_back(exp);
        repeat (hold) @(negedge clk);
        movement = 4'h0;
        @(negedge clk);
        pop_check(tag);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        movement    = 4'h0;

        // 1: reset, idle output stays zero
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("reset_idle", direction, 4'b0000);
        end

        // 2: single east press, then held through idle
        press("east_first", 4'h6, 1, 4'b0010);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("east_hold", direction, 4'b0010);
        end

        // 3: east twice hits the east wall
        do_reset(1);
        press("east_x2", 4'h6, 1, 4'b0010);
        press("east_wall", 4'h6, 1, 4'b0000);

        // 4: north, north wall, south
        press("north_y0", 4'h8, 1, 4'b0001);
        press("north_wall", 4'h8, 1, 4'b0000);
        press("south_y1", 4'h2, 1, 4'b0100);

        // 5: held west counts once, then 4'h5 directly after leaves it alone
        movement = 4'h4;
        exp_q.push_back(4'b1000);
        repeat (10) @(negedge clk);
        movement = 4'h5;
        exp_q.push_back(4'b1000);
        @(negedge clk);
        pop_check("west_held");
        movement = 4'h0;
        @(negedge clk);
        pop_check("invalid_5");
        @(negedge clk);
        // x should now be 1: one more west accepted, the next blocked
        press("west_x0", 4'h4, 1, 4'b1000);
        press("west_wall", 4'h4, 1, 4'b0000);
        press("invalid_f", 4'hF, 1, 4'b0000);
        press("south_y2", 4'h2, 1, 4'b0100);
        press("south_wall", 4'h2, 1, 4'b0000);

        // 6: reset after a move restores the start room
        do_reset(1);
        @(negedge clk);
        check_eq("post_reset", direction, 4'b0000);
        press("east_after_rst", 4'h6, 1, 4'b0010);

        // Reset landing on the evaluation edge discards the press; the code still
        // held afterwards counts as a fresh press.
        do_reset(1);
        @(negedge clk);
        movement = 4'h6;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_press_rst", direction, 4'b0000);
        @(negedge clk);
        check_eq("held_thru_rst0", direction, 4'b0000);
        @(negedge clk);
        check_eq("held_thru_rst1", direction, 4'b0010);
        movement = 4'h0;
        repeat (2) @(negedge clk);
        press("east_wall_2", 4'h6, 1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
